match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of players/paddles, legal range 2..4.
REQ-002 Parameter SCORE_W, default 4: width of each player's score counter.
REQ-003 Parameter WIN_SCORE, default 11: minimum score needed to win.
REQ-004 Parameter WIN_BY, default 2: required lead over every other player; 1 disables deuce play.
REQ-005 Parameter SERVE_DELAY_MS, default 1000: milliseconds spent in SERVE before the ball is released.
REQ-006 Parameter POINT_PAUSE_MS, default 500: milliseconds spent in POINT after a goal.
REQ-007 Port clk, input, 1: 50 MHz system clock; all logic is in this single clock domain.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port clk_1ms, input, 1: single-cycle strobe in the clk domain, one per millisecond.
REQ-010 Port start, input, 1: single-cycle start/restart request.
REQ-011 Port pause_req, input, 1: single-cycle pause/resume toggle.
REQ-012 Port goal_valid, input, 1: single-cycle strobe marking a scored point.
REQ-013 Port goal_player, input, 2: index of the scoring player; sampled only when goal_valid=1.
REQ-014 Port game_state, output, 3: current state encoding.
REQ-015 Port scores, output, NUM_PLAYERS*SCORE_W: packed scores, with player i at bits [i*SCORE_W +: SCORE_W].
REQ-016 Port server, output, 2: index of the player serving next.
REQ-017 Port ball_enable, output, 1: high only while the state is PLAY.
REQ-018 Port ball_reset, output, 1: one-cycle pulse on every entry to SERVE.
REQ-019 Port winner, output, 2: index of the winning player; valid while winner_valid=1.
REQ-020 Port winner_valid, output, 1: high only while the state is GAME_OVER.

Function
REQ-021 States and encodings SHALL be IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, GAME_OVER=5; codes 6 and 7 SHALL recover to IDLE on the next clock.
REQ-022 IDLE: start SHALL clear all scores, set server=0, and move to SERVE on the next clock.
REQ-023 SERVE: a millisecond counter SHALL load SERVE_DELAY_MS on entry and decrement on each clk_1ms; at the clk_1ms that takes it to 0 the state SHALL move to PLAY.
REQ-024 PLAY: when goal_valid=1 and goal_player<NUM_PLAYERS, the scorer's score SHALL increment at the next clock edge and the state SHALL become POINT at that same edge.
REQ-025 A goal with goal_player>=NUM_PLAYERS SHALL be ignored; goal_valid outside PLAY SHALL be ignored.
REQ-026 Scores SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-027 The win test SHALL be evaluated on the updated score: scorer's score >= WIN_SCORE and (scorer's score minus the maximum of all other scores) >= WIN_BY.
REQ-028 POINT: the counter SHALL load POINT_PAUSE_MS; on expiry the state SHALL go to GAME_OVER if the win test held, otherwise to SERVE with server=(scorer+1) mod NUM_PLAYERS.
REQ-029 If a score saturates without the win test being met, the state SHALL go to GAME_OVER with the highest scorer as winner; ties SHALL resolve to the lowest index.
REQ-030 pause_req in SERVE or PLAY SHALL enter PAUSED and record the return state; the counter SHALL be frozen and ball_enable=0 while paused.
REQ-031 pause_req in PAUSED SHALL return to the recorded state with the counter value unchanged; pause_req in any other state SHALL be ignored.
REQ-032 If goal_valid and pause_req arrive in the same PLAY cycle, the goal SHALL take priority and the pause SHALL be dropped.
REQ-033 GAME_OVER: winner and scores SHALL be held; start SHALL clear scores, set server=0, and enter SERVE.
REQ-034 start in SERVE, PLAY, POINT or PAUSED SHALL restart the match exactly as it does from IDLE, taking priority over every other input in that cycle.
REQ-035 All outputs SHALL be registered, except ball_enable and winner_valid, which are decoded from state.

Reset
REQ-036 On reset: state=IDLE, scores=0, server=0, winner=0, counter=0, ball_reset=0, and the recorded pause-return state=SERVE.
REQ-037 Assertion of reset mid-operation SHALL abandon any timer or pending point immediately; no pulse SHALL be emitted on reset release.

Structure
REQ-038 The state encodings, the default SCORE_W and the player-index width SHALL live in a shared package, pong_pkg.
REQ-039 The millisecond down-counter SHALL be a sub-module, ms_timer, with load, freeze, tick and expire ports.

Verification
REQ-040 Check reset to start: start pulse -> ball_reset high for 1 cycle; PLAY reached after 1000 clk_1ms strobes (use SERVE_DELAY_MS=4 in the bench).
REQ-041 Check a normal win: P0 scores 11 goals while P1 has 3 -> GAME_OVER, winner=0, scores=0x3B.
REQ-042 Check deuce: 10-10, then P1 scores twice -> still in play at 10-11; GAME_OVER at 10-12 with winner=1.
REQ-043 Check pause: pause_req with SERVE counter at 2 -> counter held across 50 strobes; resume -> PLAY after exactly 2 more strobes.
REQ-044 Check collision and illegal input: goal_valid plus pause_req in the same PLAY cycle -> POINT, not PAUSED; goal_player=3 with NUM_PLAYERS=2 -> ignored.
REQ-045 Check saturation: SCORE_W=2, WIN_SCORE=5 -> score saturates at 3 and GAME_OVER is reached with the highest scorer as winner.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller.
//   game_state_e : state encodings visible on the game_state output
//   SCORE_W_DEF  : default width of one player's score counter
//   PLAYER_W     : width of a player index (up to four players)
package pong_pkg;

  localparam int unsigned SCORE_W_DEF = 4;
  localparam int unsigned PLAYER_W    = 2;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StPoint    = 3'd3,
    StPaused   = 3'd4,
    StGameOver = 3'd5
  } game_state_e;

endpackage

// File: rtl/ms_timer.sv
// Millisecond down-counter used for the serve delay and the post-goal pause.
//   clk, reset : system clock, asynchronous active-high reset (count clears to 0)
//   load       : load load_value (wins over tick)
//   load_value : value loaded on load
//   freeze     : hold the count, ignore tick
//   tick       : one-cycle millisecond strobe
//   expire     : high in the tick cycle that takes the count to zero
module ms_timer #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             freeze,
  input  logic             tick,
  output logic             expire
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             run;

  assign run = tick & ~freeze;
  // A zero-length delay also expires on the first tick instead of stalling.
  assign expire = run & (count_q <= CNT_W'(1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (run && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Pong match controller: serve timing, scoring, win/deuce detection, pause and restart.
//   clk, reset   : 50 MHz clock, asynchronous active-high reset
//   clk_1ms      : one-cycle millisecond strobe
//   start        : start/restart request (highest priority)
//   pause_req    : pause/resume toggle (SERVE/PLAY <-> PAUSED)
//   goal_valid   : scored-point strobe, goal_player is the scorer
//   game_state   : current state code
//   scores       : packed scores, player i at [i*SCORE_W +: SCORE_W]
//   server       : player serving next
//   ball_enable  : ball moves (PLAY only)
//   ball_reset   : one-cycle pulse on each entry to SERVE
//   winner       : winning player, valid while winner_valid (GAME_OVER only)
module match_controller
  import pong_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned SCORE_W        = SCORE_W_DEF,
  parameter int unsigned WIN_SCORE      = 11,
  parameter int unsigned WIN_BY         = 2,
  parameter int unsigned SERVE_DELAY_MS = 1000,
  parameter int unsigned POINT_PAUSE_MS = 500
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_1ms,
  input  logic                           start,
  input  logic                           pause_req,
  input  logic                           goal_valid,
  input  logic [PLAYER_W-1:0]            goal_player,
  output logic [2:0]                     game_state,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [PLAYER_W-1:0]            server,
  output logic                           ball_enable,
  output logic                           ball_reset,
  output logic [PLAYER_W-1:0]            winner,
  output logic                           winner_valid
);

  localparam int unsigned MaxDelay = (SERVE_DELAY_MS > POINT_PAUSE_MS) ? SERVE_DELAY_MS
                                                                        : POINT_PAUSE_MS;
  localparam int unsigned CntW = (MaxDelay > 0) ? $clog2(MaxDelay + 1) : 1;

  game_state_e         state_q, state_d;
  game_state_e         ret_q, ret_d;
  logic [SCORE_W-1:0]  score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]  score_d [NUM_PLAYERS];
  logic [SCORE_W-1:0]  upd [NUM_PLAYERS];
  logic [PLAYER_W-1:0] server_q, server_d;
  logic [PLAYER_W-1:0] winner_q, winner_d;
  logic [PLAYER_W-1:0] scorer_q, scorer_d;
  logic                pend_over_q, pend_over_d;
  logic [PLAYER_W-1:0] pend_winner_q, pend_winner_d;
  logic                ball_reset_q, ball_reset_d;

  logic                goal_ok;
  logic [SCORE_W-1:0]  scorer_score, other_max, lead_score;
  logic [PLAYER_W-1:0] lead_idx, server_next;
  logic                win, sat, restart;
  logic                tmr_load, tmr_freeze, tmr_expire;
  logic [CntW-1:0]     tmr_val;

  assign goal_ok = goal_valid && (32'(goal_player) < NUM_PLAYERS);
  assign server_next = (32'(scorer_q) + 1 >= NUM_PLAYERS) ? '0 : scorer_q + 1'b1;

  // Scores as they would be after this cycle's goal, plus win/saturation tests on them.
  always_comb begin
    scorer_score = '0;
    other_max    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      upd[i] = score_q[i];
      if (goal_ok && goal_player == PLAYER_W'(i) && score_q[i] != '1) begin
        upd[i] = score_q[i] + 1'b1;
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (goal_player == PLAYER_W'(i)) begin
        scorer_score = upd[i];
      end else if (upd[i] > other_max) begin
        other_max = upd[i];
      end
    end
    // Strict '>' keeps the lowest index on ties.
    lead_score = upd[0];
    lead_idx   = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (upd[i] > lead_score) begin
        lead_score = upd[i];
        lead_idx   = PLAYER_W'(i);
      end
    end
    win = (32'(scorer_score) >= WIN_SCORE) &&
          (32'(scorer_score) >= 32'(other_max) + WIN_BY);
    sat = (scorer_score == '1);
  end

  // Timer runs only in SERVE/POINT; a pause accepted in SERVE must not lose a tick.
  assign tmr_freeze = !(state_q == StServe || state_q == StPoint) ||
                      (state_q == StServe && pause_req);

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    score_d       = score_q;
    server_d      = server_q;
    winner_d      = winner_q;
    scorer_d      = scorer_q;
    pend_over_d   = pend_over_q;
    pend_winner_d = pend_winner_q;
    tmr_load      = 1'b0;
    tmr_val       = CntW'(SERVE_DELAY_MS);
    restart       = 1'b0;

    case (state_q)
      StIdle, StGameOver: restart = start;
      StServe: begin
        if (start) begin
          restart = 1'b1;
        end else if (pause_req) begin
          state_d = StPaused;
          ret_d   = StServe;
        end else if (tmr_expire) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (start) begin
          restart = 1'b1;
        end else if (goal_ok) begin
          // Goal beats a same-cycle pause request.
          state_d       = StPoint;
          score_d       = upd;
          scorer_d      = goal_player;
          pend_over_d   = win || sat;
          pend_winner_d = win ? goal_player : lead_idx;
          tmr_load      = 1'b1;
          tmr_val       = CntW'(POINT_PAUSE_MS);
        end else if (pause_req) begin
          state_d = StPaused;
          ret_d   = StPlay;
        end
      end
      StPoint: begin
        if (start) begin
          restart = 1'b1;
        end else if (tmr_expire) begin
          if (pend_over_q) begin
            state_d  = StGameOver;
            winner_d = pend_winner_q;
          end else begin
            state_d  = StServe;
            server_d = server_next;
            tmr_load = 1'b1;
          end
        end
      end
      StPaused: begin
        if (start) begin
          restart = 1'b1;
        end else if (pause_req) begin
          state_d = ret_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (restart) begin
      state_d  = StServe;
      server_d = '0;
      tmr_load = 1'b1;
      tmr_val  = CntW'(SERVE_DELAY_MS);
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_d[i] = '0;
      end
    end
  end

  assign ball_reset_d = (state_d == StServe) && ((state_q != StServe) || restart);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ret_q         <= StServe;
      server_q      <= '0;
      winner_q      <= '0;
      scorer_q      <= '0;
      pend_over_q   <= 1'b0;
      pend_winner_q <= '0;
      ball_reset_q  <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      server_q      <= server_d;
      winner_q      <= winner_d;
      scorer_q      <= scorer_d;
      pend_over_q   <= pend_over_d;
      pend_winner_q <= pend_winner_d;
      ball_reset_q  <= ball_reset_d;
      score_q       <= score_d;
    end
  end

  ms_timer #(
    .CNT_W (CntW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_val),
    .freeze     (tmr_freeze),
    .tick       (clk_1ms),
    .expire     (tmr_expire)
  );

  always_comb begin
    scores = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      scores[i*SCORE_W +: SCORE_W] = score_q[i];
    end
  end

  assign game_state   = state_q;
  assign server       = server_q;
  assign winner       = winner_q;
  assign ball_reset   = ball_reset_q;
  assign ball_enable  = (state_q == StPlay);
  assign winner_valid = (state_q == StGameOver);

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: a default-sized instance (short timers) and a
// 2-bit-score instance for saturation, sharing the same stimulus.
module tb_match_controller;
  import pong_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned PD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_1ms = 1'b0;
  logic       start = 1'b0;
  logic       pause_req = 1'b0;
  logic       goal_valid = 1'b0;
  logic [1:0] goal_player = 2'd0;

  logic [2:0] a_state, b_state;
  logic [7:0] a_scores;
  logic [3:0] b_scores;
  logic [1:0] a_server, b_server, a_winner, b_winner;
  logic       a_ball_enable, a_ball_reset, a_winner_valid;
  logic       b_ball_enable, b_ball_reset, b_winner_valid;

  match_controller #(
    .NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(11), .WIN_BY(2),
    .SERVE_DELAY_MS(SD), .POINT_PAUSE_MS(PD)
  ) dut_a (
    .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .start(start), .pause_req(pause_req),
    .goal_valid(goal_valid), .goal_player(goal_player), .game_state(a_state),
    .scores(a_scores), .server(a_server), .ball_enable(a_ball_enable),
    .ball_reset(a_ball_reset), .winner(a_winner), .winner_valid(a_winner_valid)
  );

  match_controller #(
    .NUM_PLAYERS(2), .SCORE_W(2), .WIN_SCORE(5), .WIN_BY(2),
    .SERVE_DELAY_MS(SD), .POINT_PAUSE_MS(PD)
  ) dut_b (
    .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .start(start), .pause_req(pause_req),
    .goal_valid(goal_valid), .goal_player(goal_player), .game_state(b_state),
    .scores(b_scores), .server(b_server), .ball_enable(b_ball_enable),
    .ball_reset(b_ball_reset), .winner(b_winner), .winner_valid(b_winner_valid)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] scores;
    logic [2:0] state;
  } exp_t;

  typedef struct {
    bit         do_start;
    logic [1:0] player;
    int         n;
    logic [7:0] exp_scores;
    logic [2:0] exp_state;
    logic [1:0] exp_winner;
  } seg_t;

  exp_t       sb_q[$];
  seg_t       segs[7];
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_scores = 8'h00;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick_ms();
    @(negedge clk);
    clk_1ms = 1'b1;
    @(negedge clk);
    clk_1ms = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_pause();
    @(negedge clk);
    pause_req = 1'b1;
    @(negedge clk);
    pause_req = 1'b0;
  endtask

  task automatic check_sb();
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: actual=0 required=1 entries");
    end else begin
      e = sb_q.pop_front();
      chk("goal_scores", a_scores, e.scores);
      chk("goal_state", 8'(a_state), 8'(e.state));
    end
  endtask

  // Drive one goal strobe (optionally with a colliding pause) and check the result.
  task automatic do_goal(input logic [1:0] p, input logic with_pause,
                         input logic [7:0] exp_sc, input logic [2:0] exp_st);
    sb_q.push_back('{scores: exp_sc, state: exp_st});
    @(negedge clk);
    goal_valid  = 1'b1;
    goal_player = p;
    pause_req   = with_pause;
    @(negedge clk);
    goal_valid = 1'b0;
    pause_req  = 1'b0;
    check_sb();
  endtask

  // Full serve -> play -> goal -> point cycle for player p.
  task automatic rally(input logic [1:0] p, input logic [2:0] final_st);
    logic [7:0] exp_sc;
    for (int i = 0; i < SD; i++) tick_ms();
    chk("serve_to_play", 8'(a_state), 8'(StPlay));
    exp_sc   = m_scores + ((p == 2'd0) ? 8'h01 : 8'h10);
    m_scores = exp_sc;
    do_goal(p, 1'b0, exp_sc, StPoint);
    for (int i = 0; i < PD; i++) tick_ms();
    chk("after_point", 8'(a_state), 8'(final_st));
    if (final_st == 3'd1) begin
      chk("next_server", 8'(a_server), (p == 2'd0) ? 8'd1 : 8'd0);
      chk("ball_reset_on_serve", 8'(a_ball_reset), 8'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    segs[0] = '{1'b1, 2'd1, 3,  8'h30, StServe,    2'd0};
    segs[1] = '{1'b0, 2'd0, 10, 8'h3A, StServe,    2'd0};
    segs[2] = '{1'b0, 2'd0, 1,  8'h3B, StGameOver, 2'd0};
    segs[3] = '{1'b1, 2'd0, 10, 8'h0A, StServe,    2'd0};
    segs[4] = '{1'b0, 2'd1, 10, 8'hAA, StServe,    2'd0};
    segs[5] = '{1'b0, 2'd1, 1,  8'hBA, StServe,    2'd0};
    segs[6] = '{1'b0, 2'd1, 1,  8'hCA, StGameOver, 2'd1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", 8'(a_state), 8'(StIdle));
    chk("rst_scores", a_scores, 8'h00);
    chk("rst_server", 8'(a_server), 8'd0);
    chk("rst_winner", 8'(a_winner), 8'd0);
    chk("rst_winner_valid", 8'(a_winner_valid), 8'd0);
    chk("rst_ball_enable", 8'(a_ball_enable), 8'd0);
    chk("rst_b_scores", 8'(b_scores), 8'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_pulse", 8'(a_ball_reset), 8'd0);
    chk("idle_hold", 8'(a_state), 8'(StIdle));

    // Start, one-cycle ball_reset, serve delay
    do_start();
    chk("start_serve", 8'(a_state), 8'(StServe));
    chk("start_ball_reset", 8'(a_ball_reset), 8'd1);
    @(negedge clk);
    chk("ball_reset_one_cycle", 8'(a_ball_reset), 8'd0);
    for (int i = 0; i < SD - 1; i++) tick_ms();
    chk("serve_not_done", 8'(a_state), 8'(StServe));
    tick_ms();
    chk("serve_done", 8'(a_state), 8'(StPlay));
    chk("play_ball_enable", 8'(a_ball_enable), 8'd1);

    // Illegal scorer ignored, then goal+pause collision
    do_goal(2'd3, 1'b0, 8'h00, StPlay);
    m_scores = 8'h10;
    do_goal(2'd1, 1'b1, 8'h10, StPoint);
    chk("point_ball_enable", 8'(a_ball_enable), 8'd0);
    for (int i = 0; i < PD; i++) tick_ms();
    chk("collision_serve", 8'(a_state), 8'(StServe));
    chk("collision_server", 8'(a_server), 8'd0);

    // Pause with counter at 2, 50 frozen strobes, resume needs exactly 2 more
    repeat (2) tick_ms();
    do_pause();
    chk("paused", 8'(a_state), 8'(StPaused));
    chk("paused_ball_enable", 8'(a_ball_enable), 8'd0);
    repeat (50) tick_ms();
    chk("paused_hold", 8'(a_state), 8'(StPaused));
    do_pause();
    chk("resume_serve", 8'(a_state), 8'(StServe));
    tick_ms();
    chk("resume_one_left", 8'(a_state), 8'(StServe));
    tick_ms();
    chk("resume_play", 8'(a_state), 8'(StPlay));

    // Table: normal win (restart from PLAY) and deuce (restart from GAME_OVER)
    for (int s = 0; s < 7; s++) begin
      if (segs[s].do_start) begin
        do_start();
        m_scores = 8'h00;
        chk("restart_state", 8'(a_state), 8'(StServe));
        chk("restart_scores", a_scores, 8'h00);
        chk("restart_server", 8'(a_server), 8'd0);
        chk("restart_ball_reset", 8'(a_ball_reset), 8'd1);
      end
      for (int k = 0; k < segs[s].n; k++) begin
        rally(segs[s].player, (k == segs[s].n - 1) ? segs[s].exp_state : 3'd1);
      end
      chk("seg_scores", a_scores, segs[s].exp_scores);
      if (segs[s].exp_state == 3'd5) begin
        chk("winner", 8'(a_winner), 8'(segs[s].exp_winner));
        chk("winner_valid", 8'(a_winner_valid), 8'd1);
        do_goal(2'd1, 1'b0, segs[s].exp_scores, StGameOver);
        chk("winner_held", 8'(a_winner), 8'(segs[s].exp_winner));
      end
    end

    // Saturation on the 2-bit instance; reset taken mid-match
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_state", 8'(a_state), 8'(StIdle));
    chk("midrst_b_scores", 8'(b_scores), 8'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_pulse", 8'(a_ball_reset), 8'd0);
    do_start();
    m_scores = 8'h00;
    rally(2'd0, StServe);
    rally(2'd1, StServe);
    rally(2'd1, StServe);
    chk("sat_b_mid_state", 8'(b_state), 8'(StServe));
    chk("sat_b_mid_scores", 8'(b_scores), 8'h9);
    rally(2'd1, StServe);
    chk("sat_b_state", 8'(b_state), 8'(StGameOver));
    chk("sat_b_scores", 8'(b_scores), 8'hD);
    chk("sat_b_winner", 8'(b_winner), 8'd1);
    chk("sat_b_winner_valid", 8'(b_winner_valid), 8'd1);
    rally(2'd1, StServe);
    chk("sat_b_hold", 8'(b_scores), 8'hD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
